// File: rtl/reaction_timer_param.sv
// rtl/reaction_timer_param.sv - parametrised reaction timer: random pre-delay, N-digit BCD result, false-start detect
// Optional best-time register and display enabled by defining BEST_TIME_EN.
module reaction_timer_param #(
  parameter int DIV       = 50000,
  parameter int NDIGITS   = 3,
  parameter int MIN_DELAY = 1000,
  parameter int RAND_BITS = 11
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Startn,
  input  logic                 Pushn,
  input  logic                 ShowBest,
  output logic                 LEDn,
  output logic                 Foul,
  output logic                 Overflow,
  output logic                 NewBest,
  output logic [4*NDIGITS-1:0] BCD,
  output logic [7*NDIGITS-1:0] Segs
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = $clog2(MIN_DELAY + (1 << RAND_BITS)) + 1;
  localparam int BW = 4 * NDIGITS;
  localparam logic [BW-1:0] ALL_NINES = {NDIGITS{4'h9}};
  localparam logic [6:0]    SEG_DASH  = 7'b1111110;

  typedef enum logic [2:0] {IDLE, DELAY, GO, SHOW, FOUL} state_t;

  state_t        state;
  logic [2:0]    start_sync;
  logic [2:0]    push_sync;
  logic          start_evt;
  logic          push_evt;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [15:0]   lfsr;
  logic [DW-1:0] dly;
  logic [BW-1:0] result;
  logic [BW-1:0] disp;

  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low, a = bit 6 .. g = bit 0; non-BCD nibbles blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Bit 0 is the metastability flop; events fire on the falling edge seen between bits 1 and 2.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      start_sync <= 3'b111;
      push_sync  <= 3'b111;
    end else begin
      start_sync <= {start_sync[1:0], Startn};
      push_sync  <= {push_sync[1:0], Pushn};
    end
  end

  assign start_evt = start_sync[2] & ~start_sync[1];
  assign push_evt  = push_sync[2] & ~push_sync[1];

  assign tick = (tick_cnt == CW'(DIV - 1));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tick_cnt <= '0;
      lfsr     <= 16'hACE1;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      dly      <= '0;
      result   <= '0;
      LEDn     <= 1'b1;
      Foul     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, SHOW, FOUL: begin
          if (start_evt) begin
            state    <= DELAY;
            dly      <= DW'(MIN_DELAY) + DW'(lfsr[RAND_BITS-1:0]);
            result   <= '0;
            Overflow <= 1'b0;
            Foul     <= 1'b0;
          end
        end
        DELAY: begin
          if (push_evt) begin
            state <= FOUL;
            Foul  <= 1'b1;
          end else if (tick) begin
            if (dly == DW'(1)) begin
              state <= GO;
              LEDn  <= 1'b0;
            end else begin
              dly <= dly - DW'(1);
            end
          end
        end
        GO: begin
          // A push wins over a same-cycle tick so the shown result is the one the player saw.
          if (push_evt) begin
            state <= SHOW;
            LEDn  <= 1'b1;
          end else if (tick) begin
            if (result == ALL_NINES) begin
              state    <= SHOW;
              LEDn     <= 1'b1;
              Overflow <= 1'b1;
            end else begin
              result <= bcd_inc(result);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BEST_TIME_EN
  logic [BW-1:0] best;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      best    <= ALL_NINES;
      NewBest <= 1'b0;
    end else begin
      NewBest <= 1'b0;
      if (state == GO && push_evt && result < best) begin
        best    <= result;
        NewBest <= 1'b1;
      end
    end
  end

  assign disp = (ShowBest && state != FOUL) ? best : result;
`else
  logic unused_showbest;
  assign unused_showbest = ShowBest;
  assign NewBest         = 1'b0;
  assign disp            = result;
`endif

  assign BCD = result;

  for (genvar i = 0; i < NDIGITS; i++) begin : g_seg
    assign Segs[7*i +: 7] = (state == FOUL) ? SEG_DASH : seg7(disp[4*i +: 4]);
  end

endmodule

// File: tb/tb_reaction_timer_param.sv
// tb/tb_reaction_timer_param.sv - directed self-checking bench for reaction_timer_param
module tb_reaction_timer_param;

  localparam int DIV       = 4;
  localparam int NDIGITS   = 2;
  localparam int MIN_DELAY = 8;
  localparam int RAND_BITS = 3;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SD = 7'b1111110;

  logic        Clock    = 1'b0;
  logic        Resetn   = 1'b0;
  logic        Startn   = 1'b1;
  logic        Pushn    = 1'b1;
  logic        ShowBest = 1'b0;
  logic        LEDn;
  logic        Foul;
  logic        Overflow;
  logic        NewBest;
  logic [7:0]  BCD;
  logic [13:0] Segs;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_cnt   = 0;
  logic [15:0] m_lfsr  = 16'hACE1;
  logic        tick_seen = 1'b0;

  always #5 Clock = ~Clock;

  reaction_timer_param #(
    .DIV(DIV), .NDIGITS(NDIGITS), .MIN_DELAY(MIN_DELAY), .RAND_BITS(RAND_BITS)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Startn(Startn), .Pushn(Pushn), .ShowBest(ShowBest),
    .LEDn(LEDn), .Foul(Foul), .Overflow(Overflow), .NewBest(NewBest), .BCD(BCD), .Segs(Segs)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; tick counter and LFSR reference models advance with it.
  task automatic step();
    @(posedge Clock);
    tick_seen = (m_cnt == DIV - 1);
    m_cnt     = tick_seen ? 0 : m_cnt + 1;
    m_lfsr    = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    Resetn   = 1'b0;
    Startn   = 1'b1;
    Pushn    = 1'b1;
    ShowBest = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    m_cnt  = 0;
    m_lfsr = 16'hACE1;
    Resetn = 1'b1;
  endtask

  // Returns the LFSR value the DUT sees on the edge that acts on the press.
  task automatic press_start(output logic [15:0] lf);
    Startn = 1'b0;
    step();
    step();
    lf = m_lfsr;
    step();
    Startn = 1'b1;
  endtask

  task automatic press_push();
    Pushn = 1'b0;
    steps(3);
    Pushn = 1'b1;
  endtask

  task automatic wait_led(output int ticks);
    ticks = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (tick_seen) ticks++;
      if (LEDn == 1'b0) break;
    end
  endtask

  task automatic go_ticks(input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 2000 && cnt < n; i++) begin
      step();
      if (tick_seen) cnt++;
    end
  endtask

  task automatic start_round(input string tag);
    logic [15:0] lf;
    int          t;
    press_start(lf);
    wait_led(t);
    check_val({tag, "_delay_ticks"}, t, MIN_DELAY + int'(lf[RAND_BITS-1:0]));
    check_val({tag, "_led_on"}, LEDn, 1'b0);
    check_val({tag, "_bcd_at_led"}, BCD, 8'h00);
  endtask

  task automatic play_round(input string tag, input int score, input logic [7:0] score_bcd, input logic exp_nb);
    steps(4);
    start_round(tag);
    go_ticks(score);
    press_push();
    check_val({tag, "_bcd"}, BCD, score_bcd);
    check_val({tag, "_newbest"}, NewBest, exp_nb);
    step();
    check_val({tag, "_newbest_1cyc"}, NewBest, 1'b0);
  endtask

  initial begin
    logic [15:0] lf;
    int          t;
    logic        lit;

    do_reset();
    check_val("rst_ledn", LEDn, 1'b1);
    check_val("rst_foul", Foul, 1'b0);
    check_val("rst_ovf", Overflow, 1'b0);
    check_val("rst_newbest", NewBest, 1'b0);
    check_val("rst_bcd", BCD, 8'h00);
    check_val("rst_segs", Segs, {S0, S0});

    // Normal round: push after 37 ticks, clear of any tick edge.
    steps(3);
    start_round("r37");
    go_ticks(37);
    press_push();
    check_val("r37_ledn", LEDn, 1'b1);
    check_val("r37_bcd", BCD, 8'h37);
    check_val("r37_segs", Segs, {S3, S7});
    steps(4);
    press_push();
    steps(8);
    check_val("show_push_ignored", BCD, 8'h37);

    // False start.
    press_start(lf);
    steps(2);
    press_push();
    check_val("foul_flag", Foul, 1'b1);
    check_val("foul_ledn", LEDn, 1'b1);
    check_val("foul_segs", Segs, {SD, SD});
    check_val("foul_bcd", BCD, 8'h00);
    lit = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (LEDn == 1'b0) lit = 1'b1;
    end
    check_val("foul_led_never_lit", lit, 1'b0);
    press_start(lf);
    check_val("foul_cleared", Foul, 1'b0);
    wait_led(t);
    check_val("refoul_delay_ticks", t, MIN_DELAY + int'(lf[RAND_BITS-1:0]));

    // Push lands on the same edge as a tick: result must stay 19.
    go_ticks(19);
    step();
    press_push();
    check_val("r19_bcd", BCD, 8'h19);
    check_val("r19_segs", Segs, {S1, S9});
    check_val("r19_ledn", LEDn, 1'b1);

    // Overflow.
    steps(4);
    start_round("ovf");
    go_ticks(100);
    check_val("ovf_bcd", BCD, 8'h99);
    check_val("ovf_flag", Overflow, 1'b1);
    check_val("ovf_ledn", LEDn, 1'b1);
    check_val("ovf_segs", Segs, {S9, S9});
    steps(4);
    press_start(lf);
    check_val("ovf_cleared", Overflow, 1'b0);
    check_val("ovf_bcd_cleared", BCD, 8'h00);
    wait_led(t);
    check_val("ovf_next_delay", t, MIN_DELAY + int'(lf[RAND_BITS-1:0]));

    // Reset in the middle of GO aborts without waiting for a clock edge.
    go_ticks(5);
    Resetn = 1'b0;
    #1;
    check_val("midrst_ledn", LEDn, 1'b1);
    check_val("midrst_bcd", BCD, 8'h00);
    do_reset();

    // Best-time rounds (NewBest stays 0 when the feature is compiled out).
`ifdef BEST_TIME_EN
    play_round("b45", 45, 8'h45, 1'b1);
    play_round("b30", 30, 8'h30, 1'b1);
    play_round("b52", 52, 8'h52, 1'b0);
    ShowBest = 1'b1;
    #1;
    check_val("best_segs", Segs, {S3, S0});
`else
    play_round("b45", 45, 8'h45, 1'b0);
    play_round("b30", 30, 8'h30, 1'b0);
    play_round("b52", 52, 8'h52, 1'b0);
    ShowBest = 1'b1;
    #1;
    check_val("best_segs", Segs, {S5, S2});
`endif
    check_val("best_bcd_live", BCD, 8'h52);
    ShowBest = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
